// File: rtl/cache_pkg.sv
// cache_pkg: shared sizes, FSM states, line layout and address helpers for cache_ctrl
`timescale 1ns/1ps
package cache_pkg;
  localparam int NUM_SETS = 64;
  localparam int WAYS = 4;
  localparam int ADDR_WID = 32;
  localparam int WORD_WID = 64;
  localparam int IDX_WID = $clog2(NUM_SETS);
  localparam int AGE_WID = $clog2(WAYS);
  localparam int TAG_WID = ADDR_WID - IDX_WID;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} cache_state_t;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TAG_WID-1:0]  tag;
    logic [WORD_WID-1:0] data;
  } line_t;

  function automatic logic [IDX_WID-1:0] idx_of(input logic [ADDR_WID-1:0] addr);
    return addr[IDX_WID-1:0];
  endfunction

  function automatic logic [TAG_WID-1:0] tag_of(input logic [ADDR_WID-1:0] addr);
    return addr[ADDR_WID-1:IDX_WID];
  endfunction
endpackage

// File: rtl/cache_lru_ages.sv
// cache_lru_ages: per-set true-LRU age vectors; oldest way (age WAYS-1) is the victim
`timescale 1ns/1ps
module cache_lru_ages #(
  parameter int NUM_SETS = 64,
  parameter int WAYS = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [$clog2(NUM_SETS)-1:0] set_i,
  input  logic                        touch_i,
  input  logic [$clog2(WAYS)-1:0]     way_i,
  output logic [$clog2(WAYS)-1:0]     victim_o,
  output logic                        victim_valid_o
);
  localparam int AW = $clog2(WAYS);

  logic [AW-1:0] ages [NUM_SETS][WAYS];

  // find the way whose age marks it least recently used
  always_comb begin
    victim_o = '0;
    victim_valid_o = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (ages[set_i][w] == AW'(WAYS - 1)) begin
        victim_o = AW'(w);
        victim_valid_o = 1'b1;
      end
    end
  end

  // touched way becomes youngest; younger ways age by one so ages stay a permutation
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < WAYS; w++)
          ages[s][w] <= AW'(w);
    end else if (touch_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AW'(w) == way_i) ages[set_i][w] <= '0;
        else if (ages[set_i][w] < ages[set_i][way_i]) ages[set_i][w] <= ages[set_i][w] + AW'(1);
      end
    end
  end
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: write-back, write-allocate set-associative cache controller with one-word lines
`timescale 1ns/1ps
module cache_ctrl
  import cache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_WID-1:0] req_addr_i,
  input  logic [WORD_WID-1:0] req_wdata_i,
  output logic                resp_valid_o,
  output logic                resp_hit_o,
  output logic [WORD_WID-1:0] resp_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_WID-1:0] mem_addr_o,
  output logic [WORD_WID-1:0] mem_wdata_o,
  input  logic                mem_ack_i,
  input  logic [WORD_WID-1:0] mem_rdata_i
);
  cache_state_t state, next;
  line_t lines [NUM_SETS][WAYS];
  logic we_q, hit_q, hit, inv, wr, touch, lru_ok;
  logic [ADDR_WID-1:0] addr_q;
  logic [WORD_WID-1:0] wdata_q, rdata_q;
  logic [AGE_WID-1:0] vway_q, hit_way, inv_way, lru_way, victim, wr_way;
  logic [IDX_WID-1:0] idx;
  logic [TAG_WID-1:0] tag;
  line_t vline, lv, wr_line;

  assign idx = idx_of(addr_q);
  assign tag = tag_of(addr_q);
  assign vline = lines[idx][vway_q];
  assign lv = lines[idx][victim];
  assign victim = (inv || !lru_ok) ? inv_way : lru_way;
  assign wr_line = {1'b1, state != REFILL, tag, state == REFILL ? mem_rdata_i : wdata_q};

  cache_lru_ages #(.NUM_SETS(NUM_SETS), .WAYS(WAYS)) u_lru (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .set_i(idx),
    .touch_i(touch),
    .way_i(wr_way),
    .victim_o(lru_way),
    .victim_valid_o(lru_ok)
  );

  // tag compare across the set and lowest-index invalid way
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lines[idx][w].valid && lines[idx][w].tag == tag) begin
        hit = 1'b1;
        hit_way = AGE_WID'(w);
      end
      if (!lines[idx][w].valid) begin
        inv = 1'b1;
        inv_way = AGE_WID'(w);
      end
    end
  end

  // next state plus line write / LRU touch strobes
  always_comb begin
    next = state;
    wr = 1'b0;
    touch = 1'b0;
    wr_way = vway_q;
    case (state)
      IDLE: next = req_valid_i ? LOOKUP : IDLE;
      LOOKUP: begin
        if (hit) begin
          next = RESPOND;
          wr = we_q;
          touch = 1'b1;
          wr_way = hit_way;
        end else if (lv.valid && lv.dirty) begin
          next = WRITEBACK;
        end else if (we_q) begin
          next = RESPOND;
          wr = 1'b1;
          touch = 1'b1;
          wr_way = victim;
        end else begin
          next = REFILL;
        end
      end
      WRITEBACK: if (mem_ack_i) begin
        next = we_q ? RESPOND : REFILL;
        wr = we_q;
        touch = we_q;
      end
      REFILL: if (mem_ack_i) begin
        next = RESPOND;
        wr = 1'b1;
        touch = 1'b1;
      end
      RESPOND: next = IDLE;
      default: next = IDLE;
    endcase
  end

  // state register; reset aborts any memory transaction at once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else state <= next;
  end

  // latch the accepted request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && req_valid_i) begin
      we_q <= req_we_i;
      addr_q <= req_addr_i;
      wdata_q <= req_wdata_i;
    end
  end

  // lookup outcome, chosen victim and response data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_q <= 1'b0;
      vway_q <= '0;
      rdata_q <= '0;
    end else if (state == LOOKUP) begin
      hit_q <= hit;
      vway_q <= victim;
      rdata_q <= (hit && !we_q) ? lines[idx][hit_way].data : '0;
    end else if (state == REFILL && mem_ack_i) begin
      rdata_q <= mem_rdata_i;
    end
  end

  // line storage; reset only invalidates, tag/data are don't-care until refilled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          lines[s][w].valid <= 1'b0;
          lines[s][w].dirty <= 1'b0;
        end
    end else if (wr) begin
      lines[idx][wr_way] <= wr_line;
    end
  end

  assign req_ready_o = state == IDLE;
  assign resp_valid_o = state == RESPOND;
  assign resp_hit_o = resp_valid_o && hit_q;
  assign resp_rdata_o = resp_valid_o ? rdata_q : '0;
  assign mem_req_o = state == WRITEBACK || state == REFILL;
  assign mem_we_o = state == WRITEBACK;
  assign mem_addr_o = state == WRITEBACK ? {vline.tag, idx} : state == REFILL ? addr_q : '0;
  assign mem_wdata_o = state == WRITEBACK ? vline.data : '0;
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed scoreboard bench for cache_ctrl with a queued memory model
`timescale 1ns/1ps
module tb_cache_ctrl;
  typedef struct {
    logic        hit;
    logic [63:0] rdata;
    int          lat;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          wait_cycles;
  } mem_t;

  logic clk = 0, rst = 1, req_valid = 0, req_we = 0, mem_ack = 0;
  logic [31:0] req_addr = 0;
  logic [63:0] req_wdata = 0, mem_rdata = 0;
  logic req_ready, resp_valid, resp_hit, mem_req, mem_we;
  logic [63:0] resp_rdata, mem_wdata;
  logic [31:0] mem_addr;
  int checks = 0, errors = 0, cyc = 0, acc = 0, done = 0;
  resp_t resp_q[$];
  mem_t mem_q[$];

  cache_ctrl dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i(req_we),
    .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid),
    .resp_hit_o(resp_hit),
    .resp_rdata_o(resp_rdata),
    .mem_req_o(mem_req),
    .mem_we_o(mem_we),
    .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] md(input logic [31:0] a);
    return {32'h0, a} ^ 64'hA0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mem(input logic we, input logic [31:0] a, input logic [63:0] wd, input int wt);
    mem_t m;
    m.we = we;
    m.addr = a;
    m.wdata = wd;
    m.rdata = md(a);
    m.wait_cycles = wt;
    mem_q.push_back(m);
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [63:0] wd,
                       input logic eh, input logic [63:0] er, input int el);
    resp_t e;
    int d0, n;
    e.hit = eh;
    e.rdata = er;
    e.lat = el;
    resp_q.push_back(e);
    d0 = done;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1;
    req_we = we;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 0;
    n = 0;
    while (done == d0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done == d0) begin
      chk("resp_timeout", 1, 0);
      resp_q.delete();
    end
  endtask

  // response monitor: pops the scoreboard whenever a completion is presented
  always @(negedge clk) begin
    resp_t e;
    if (!rst && resp_valid) begin
      if (resp_q.size() == 0) chk("resp_unexpected", 1, 0);
      else begin
        e = resp_q.pop_front();
        chk("resp_hit", resp_hit, e.hit);
        chk("resp_rdata", resp_rdata, e.rdata);
        if (e.lat >= 0) chk("resp_latency", cyc - acc + 1, e.lat);
      end
      done++;
    end
  end

  // memory model: checks each transaction against the queue, holds ack off for wait_cycles
  initial begin : mem_model
    mem_t cur;
    bit active;
    int cnt;
    active = 0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
        mem_ack = 0;
      end else begin
        if (mem_ack) begin
          mem_ack = 0;
          active = 0;
        end
        if (!active && mem_req) begin
          if (mem_q.size() == 0) chk("mem_unexpected", 1, 0);
          else begin
            cur = mem_q.pop_front();
            active = 1;
            cnt = 0;
            chk("mem_we", mem_we, cur.we);
            chk("mem_addr", mem_addr, cur.addr);
            if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
          end
        end else if (active) begin
          chk("mem_req_held", mem_req, 1);
          chk("mem_addr_held", mem_addr, cur.addr);
          chk("mem_we_held", mem_we, cur.we);
          chk("ready_low_busy", req_ready, 0);
        end
        if (active) begin
          if (cnt == cur.wait_cycles) begin
            mem_ack = 1;
            mem_rdata = cur.rdata;
          end else cnt++;
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    // cold miss then hit
    mem(0, 32'h005, 0, 0);
    issue(0, 32'h005, 0, 0, 64'hA5, 3);
    issue(0, 32'h005, 0, 1, 64'hA5, 2);
    // fill set 5, fifth tag evicts the oldest (0x005)
    mem(0, 32'h045, 0, 0);
    issue(0, 32'h045, 0, 0, md(32'h045), 3);
    mem(0, 32'h085, 0, 0);
    issue(0, 32'h085, 0, 0, md(32'h085), 3);
    mem(0, 32'h0C5, 0, 0);
    issue(0, 32'h0C5, 0, 0, md(32'h0C5), 3);
    mem(0, 32'h105, 0, 0);
    issue(0, 32'h105, 0, 0, md(32'h105), 3);
    issue(0, 32'h045, 0, 1, md(32'h045), 2);
    mem(0, 32'h005, 0, 0);
    issue(0, 32'h005, 0, 0, 64'hA5, 3);
    // dirty line aged to LRU, then evicted with writeback
    issue(1, 32'h045, 64'h1234, 1, 0, 2);
    mem(0, 32'h185, 0, 0);
    issue(0, 32'h185, 0, 0, md(32'h185), 3);
    mem(0, 32'h1C5, 0, 0);
    issue(0, 32'h1C5, 0, 0, md(32'h1C5), 3);
    mem(0, 32'h205, 0, 0);
    issue(0, 32'h205, 0, 0, md(32'h205), 3);
    mem(1, 32'h045, 64'h1234, 0);
    mem(0, 32'h145, 0, 0);
    issue(0, 32'h145, 0, 0, md(32'h145), 4);
    // slow memory with ignored request pulses
    mem(0, 32'h00A, 0, 10);
    fork
      issue(0, 32'h00A, 0, 0, md(32'h00A), 13);
      begin
        repeat (5) @(negedge clk);
        repeat (3) begin
          req_valid = 1;
          req_we = 1;
          req_addr = 32'h00B;
          @(negedge clk);
          req_valid = 0;
          @(negedge clk);
        end
      end
    join
    mem(0, 32'h00B, 0, 0);
    issue(0, 32'h00B, 0, 0, md(32'h00B), 3);
    // reset in the middle of a refill
    mem(0, 32'h00C, 0, 30);
    @(negedge clk);
    req_valid = 1;
    req_we = 0;
    req_addr = 32'h00C;
    @(posedge clk);
    #1;
    req_valid = 0;
    repeat (4) @(negedge clk);
    chk("mem_req_in_refill", mem_req, 1);
    #2;
    rst = 1;
    #1;
    chk("mem_req_async_reset", mem_req, 0);
    chk("ready_async_reset", req_ready, 1);
    mem_q.delete();
    resp_q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    mem(0, 32'h005, 0, 0);
    issue(0, 32'h005, 0, 0, 64'hA5, 3);
    // store miss to a clean set writes directly, then hits
    issue(1, 32'h207, 64'h55, 0, 0, 2);
    issue(0, 32'h207, 0, 1, 64'h55, 2);
    repeat (3) @(negedge clk);
    chk("resp_q_drained", resp_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
